// File: rtl/ped_request_unit.sv
// Pedestrian request unit: synchronises and debounces the crossing button,
// latches a request towards the crossing controller, follows the controller's
// pedestrian lamps to drive walk/wait/beep indications, and enforces a minimum
// gap between crossings so traffic green cannot be starved.
module ped_request_unit #(
    parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
    parameter int unsigned MIN_GAP_CYCLES   = 300_000_000,
    parameter int unsigned BEEP_HALF_CYCLES = 25_000_000,
    parameter int unsigned CNT_W            = 29
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic PG,
    input  logic PY,
    input  logic PR,
    output logic go,
    output logic wait_led,
    output logic walk_led,
    output logic beep
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLDOFF = 3'd1,
        S_REQ     = 3'd2,
        S_WALK    = 3'd3,
        S_CLEAR   = 3'd4
    } state_t;

    // The debounce counter arms on the first differing sample, so a held level
    // is accepted DEBOUNCE_CYCLES+2 edges after btn is first sampled.
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(MIN_GAP_CYCLES);
    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_prev_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic             press;

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             go_q, go_d;
    logic             wait_q, wait_d;
    logic             walk_q, walk_d;
    logic             beep_q, beep_d;

    logic             lamps_bad;
    logic             gap_free;
    logic             exit_walk;

    // Two-flop synchroniser followed by a consecutive-sample debouncer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            db_cnt_q      <= '0;
        end else begin
            sync1_q       <= btn;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            if (sync2_q == stable_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                stable_q <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + CNT_ONE;
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

    // Contradictory (PG+PY) or dark lamps freeze the unit in place.
    assign lamps_bad = (PG & PY) | ~(PG | PY | PR);
    // The holdoff expires on the edge where the gap counter reaches zero.
    assign gap_free  = (gap_q <= CNT_ONE);

    // Next-state, gap counter, beep cadence and registered output values.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        bcnt_d    = bcnt_q;
        walk_d    = walk_q;
        beep_d    = beep_q;
        exit_walk = 1'b0;

        if (!lamps_bad) begin
            case (state_q)
                S_IDLE: begin
                    if (PG)
                        state_d = S_WALK;
                    else if (press)
                        state_d = gap_free ? S_REQ : S_HOLDOFF;
                end
                S_HOLDOFF: begin
                    if (PG)
                        state_d = S_WALK;
                    else if (gap_free)
                        state_d = S_REQ;
                end
                S_REQ: begin
                    if (PG)
                        state_d = S_WALK;
                end
                S_WALK: begin
                    if (press)
                        pending_d = 1'b1;
                    if (PY)
                        state_d = S_CLEAR;
                    else if (PR && !PG)
                        exit_walk = 1'b1;
                end
                S_CLEAR: begin
                    if (press)
                        pending_d = 1'b1;
                    if (PR)
                        exit_walk = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase

            // A request made while the crossing was in use is served after the gap.
            if (exit_walk) begin
                state_d   = pending_d ? S_HOLDOFF : S_IDLE;
                pending_d = 1'b0;
            end

            case (state_d)
                S_WALK: begin
                    walk_d = 1'b1;
                    beep_d = 1'b0;
                    bcnt_d = '0;
                end
                S_CLEAR: begin
                    if (state_q != S_CLEAR) begin
                        walk_d = 1'b1;
                        beep_d = 1'b1;
                        bcnt_d = '0;
                    end else if (bcnt_q == BEEP_LAST) begin
                        walk_d = ~walk_q;
                        beep_d = ~beep_q;
                        bcnt_d = '0;
                    end else begin
                        bcnt_d = bcnt_q + CNT_ONE;
                    end
                end
                default: begin
                    walk_d = 1'b0;
                    beep_d = 1'b0;
                    bcnt_d = '0;
                end
            endcase
        end

        if (exit_walk)
            gap_d = GAP_LOAD;
        else if (gap_q != '0)
            gap_d = gap_q - CNT_ONE;
        else
            gap_d = gap_q;

        go_d   = (state_d == S_REQ);
        wait_d = (state_d == S_HOLDOFF) || (state_d == S_REQ) ||
                 (((state_d == S_WALK) || (state_d == S_CLEAR)) && pending_d);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            gap_q     <= '0;
            bcnt_q    <= '0;
            go_q      <= 1'b0;
            wait_q    <= 1'b0;
            walk_q    <= 1'b0;
            beep_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            gap_q     <= gap_d;
            bcnt_q    <= bcnt_d;
            go_q      <= go_d;
            wait_q    <= wait_d;
            walk_q    <= walk_d;
            beep_q    <= beep_d;
        end
    end

    assign go       = go_q;
    assign wait_led = wait_q;
    assign walk_led = walk_q;
    assign beep     = beep_q;

endmodule

// File: tb/tb_ped_request_unit.sv
// Bench for ped_request_unit with short timing parameters. Stimulus pushes the
// expected {go,wait,walk,beep} for the coming edge into a queue; a monitor pops
// and compares just after each rising edge.
module tb_ped_request_unit;

    localparam int D = 4;
    localparam int G = 20;
    localparam int H = 3;

    logic clk, rst, btn, PG, PY, PR;
    logic go, wait_led, walk_led, beep;

    typedef struct {
        int         cyc;
        logic [3:0] exp;
        string      name;
    } sb_t;

    typedef struct {
        logic       b, pg, py, pr;
        logic [3:0] exp;
    } vec_t;

    sb_t  q[$];
    vec_t t1[20];
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;

    ped_request_unit #(
        .DEBOUNCE_CYCLES (D),
        .MIN_GAP_CYCLES  (G),
        .BEEP_HALF_CYCLES(H),
        .CNT_W           (29)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .PG      (PG),
        .PY      (PY),
        .PR      (PR),
        .go      (go),
        .wait_led(wait_led),
        .walk_led(walk_led),
        .beep    (beep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare outputs shortly after each rising edge.
    always begin
        @(posedge clk);
        #1;
        cycle++;
        while (q.size() > 0 && q[0].cyc == cycle) begin
            sb_t e;
            logic [3:0] got;
            e   = q.pop_front();
            got = {go, wait_led, walk_led, beep};
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s @edge %0d: got go/wait/walk/beep=%b expected %b",
                         e.name, cycle, got, e.exp);
            end
        end
    end

    task automatic step(input logic b, input logic pg, input logic py, input logic pr,
                        input logic [3:0] e, input string nm);
        @(negedge clk);
        rst = 1'b0; btn = b; PG = pg; PY = py; PR = pr;
        q.push_back('{cyc: cycle + 1, exp: e, name: nm});
    endtask

    task automatic rstep(input string nm);
        @(negedge clk);
        rst = 1'b1; btn = 1'b0; PG = 1'b0; PY = 1'b0; PR = 1'b1;
        q.push_back('{cyc: cycle + 1, exp: 4'b0000, name: nm});
    endtask

    // Fresh press from IDLE with no gap: go/wait at edge D+3, then release.
    task automatic press_seq(input string nm);
        for (int i = 0; i < 18; i++)
            step(i < 10, 1'b0, 1'b0, 1'b1, (i >= D + 3) ? 4'b1100 : 4'b0000, nm);
    endtask

    function automatic logic clr_b(input int j);
        return ((j / H) % 2) == 0;
    endfunction

    initial begin
        // Test 1 vectors: btn held from edge 0, PR until PG rises for edge 16.
        for (int k = 0; k < 20; k++) begin
            t1[k].b   = (k <= 10);
            t1[k].pg  = (k >= 16);
            t1[k].py  = 1'b0;
            t1[k].pr  = (k < 16);
            t1[k].exp = {(k >= D + 3 && k < 16), (k >= D + 3 && k < 16), (k >= 16), 1'b0};
        end

        rst = 1'b1; btn = 1'b0; PG = 1'b0; PY = 1'b0; PR = 1'b1;
        rstep("reset");
        rstep("reset");
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, "idle after reset");

        // Short pulses are rejected by the debouncer.
        for (int rep = 0; rep < 2; rep++)
            for (int len = 1; len <= 3; len++) begin
                for (int i = 0; i < len; i++)
                    step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, "short pulse");
                repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, "pulse gap");
            end

        // Request latency and go drop at PG.
        for (int k = 0; k < 20; k++)
            step(t1[k].b, t1[k].pg, t1[k].py, t1[k].pr, t1[k].exp, "press to walk");

        // Invalid lamp combinations hold everything.
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, "hold pg+py");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, "hold dark");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, "walk steady");

        // Clearance flashing, then press 5 edges after PR lands in HOLDOFF.
        for (int j = 0; j < 8; j++)
            step(1'b0, 1'b0, 1'b1, 1'b0, {2'b00, clr_b(j), clr_b(j)}, "clear toggle");
        for (int i = 0; i < 22; i++)
            step((i >= 5 && i <= 12), 1'b0, 1'b0, 1'b1,
                 (i >= G) ? 4'b1100 : (i >= 12) ? 4'b0100 : 4'b0000, "gap holdoff");

        // Press during WALK is remembered and served after the gap.
        for (int w = 0; w < 12; w++)
            step((w >= 1 && w <= 6), 1'b1, 1'b0, 1'b0,
                 (w >= D + 4) ? 4'b0110 : 4'b0010, "walk press");
        for (int j = 0; j < 4; j++)
            step(1'b0, 1'b0, 1'b1, 1'b0, {2'b01, clr_b(j), clr_b(j)}, "clear pending");
        for (int i = 0; i < 22; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, (i >= G) ? 4'b1100 : 4'b0100, "pending holdoff");

        // Unrequested walk is followed without raising go.
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, "walk");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, "clear entry");
        repeat (25) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, "idle");
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, "unrequested walk");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, "walk exit");
        repeat (22) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, "gap drain");

        // Reset during REQ, during CLEAR, and right after a gap load.
        press_seq("req before reset");
        rstep("reset in req");
        press_seq("press after req reset");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, "walk");
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, "clear");
        rstep("reset in clear");
        press_seq("press after clear reset");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, "walk");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, "clear");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, "exit loads gap");
        rstep("reset after exit");
        press_seq("gap cleared by reset");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
